// File: rtl/ifetch_queue_if.sv
// Fetch-queue bus bundle: ROB redirect/BHT update, ICache request/response and decode-side head.
// master = the fetch queue, slave = the surrounding core (ROB, ICache, decoder).
interface ifetch_queue_if;
    logic        jump_wrong;
    logic [31:0] jump_pc;
    logic        bht_upd_valid;
    logic [31:0] bht_upd_pc;
    logic        bht_upd_taken;
    logic        fetch_valid;
    logic [31:0] pc_to_fetch;
    logic        instr_valid;
    logic [31:0] instr_fetched;
    logic        stall_IF;
    logic        out_valid;
    logic [31:0] instr_to_decode;
    logic [31:0] pc_to_decode;
    logic        is_jump_instr;
    logic        jump_prediction;

    modport master (
        input  jump_wrong, jump_pc, bht_upd_valid, bht_upd_pc, bht_upd_taken,
        input  instr_valid, instr_fetched, stall_IF,
        output fetch_valid, pc_to_fetch,
        output out_valid, instr_to_decode, pc_to_decode, is_jump_instr, jump_prediction
    );

    modport slave (
        output jump_wrong, jump_pc, bht_upd_valid, bht_upd_pc, bht_upd_taken,
        output instr_valid, instr_fetched, stall_IF,
        input  fetch_valid, pc_to_fetch,
        input  out_valid, instr_to_decode, pc_to_decode, is_jump_instr, jump_prediction
    );
endinterface

// File: rtl/ifetch_queue.sv
// Instruction fetch unit: single-outstanding ICache requester, static JAL / BHT-predicted
// branch next-pc, and a circular instruction queue feeding decode.
module ifetch_queue #(
    parameter int unsigned QUEUE_DEPTH_LOG = 3,
    parameter int unsigned BHT_IDX_W       = 8,
    parameter logic [31:0] RESET_PC        = 32'h0
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           rdy,
    ifetch_queue_if.master ifq
);
    localparam int unsigned DEPTH = 32'd1 << QUEUE_DEPTH_LOG;
    localparam int unsigned PTR_W = QUEUE_DEPTH_LOG;
    localparam int unsigned CNT_W = QUEUE_DEPTH_LOG + 1;
    localparam int unsigned BHT_N = 32'd1 << BHT_IDX_W;

    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    typedef enum logic [1:0] {
        S_ISSUE,
        S_WAIT,
        S_DISCARD
    } state_e;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic        is_jump;
        logic        pred;
    } entry_t;

    state_e           state_q, state_d;
    logic [31:0]      pc_q, pc_d;
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    entry_t           q_mem_q [DEPTH];
    logic [1:0]       bht_q   [BHT_N];

    logic             fetch_valid_c;
    logic             push;
    logic             pop;

    logic [6:0]           opcode;
    logic [31:0]          j_imm;
    logic [31:0]          b_imm;
    logic [BHT_IDX_W-1:0] fetch_idx;
    logic                 bht_taken;
    logic [31:0]          npc;
    entry_t               new_entry;
    entry_t               head_entry;

    logic [BHT_IDX_W-1:0] upd_idx;
    logic [1:0]           upd_ctr;
    logic [1:0]           upd_next;

    // Pre-decode of the returning instruction: queue entry and next fetch pc.
    always_comb begin : predecode
        opcode    = ifq.instr_fetched[6:0];
        j_imm     = {{12{ifq.instr_fetched[31]}}, ifq.instr_fetched[19:12], ifq.instr_fetched[20],
                     ifq.instr_fetched[30:21], 1'b0};
        b_imm     = {{20{ifq.instr_fetched[31]}}, ifq.instr_fetched[7], ifq.instr_fetched[30:25],
                     ifq.instr_fetched[11:8], 1'b0};
        fetch_idx = BHT_IDX_W'(pc_q >> 2);
        bht_taken = bht_q[fetch_idx][1];
        npc       = pc_q + 32'd4;
        new_entry = '{instr: ifq.instr_fetched, pc: pc_q, is_jump: 1'b0, pred: 1'b0};
        case (opcode)
            OP_JAL: begin
                new_entry.is_jump = 1'b1;
                new_entry.pred    = 1'b1;
                npc               = pc_q + j_imm;
            end
            OP_BRANCH: begin
                new_entry.is_jump = 1'b1;
                new_entry.pred    = bht_taken;
                if (bht_taken) begin
                    npc = pc_q + b_imm;
                end
            end
            OP_JALR: begin
                new_entry.is_jump = 1'b1;
            end
            default: ;
        endcase
    end

    // Fetch FSM, redirect handling and queue pointer/count next state.
    always_comb begin : next_state
        state_d       = state_q;
        pc_d          = pc_q;
        head_d        = head_q;
        tail_d        = tail_q;
        cnt_d         = cnt_q;
        fetch_valid_c = 1'b0;
        push          = 1'b0;
        pop           = 1'b0;

        if (rst && rdy) begin
            if (ifq.jump_wrong) begin
                pc_d   = ifq.jump_pc;
                tail_d = head_q;
                cnt_d  = '0;
                // A request still in flight must have its response swallowed.
                if ((state_q != S_ISSUE) && !ifq.instr_valid) begin
                    state_d = S_DISCARD;
                end else begin
                    state_d = S_ISSUE;
                end
            end else begin
                pop = (cnt_q != '0) && !ifq.stall_IF;
                case (state_q)
                    S_ISSUE: begin
                        if (cnt_q < CNT_W'(DEPTH)) begin
                            fetch_valid_c = 1'b1;
                            state_d       = S_WAIT;
                        end
                    end
                    S_WAIT: begin
                        if (ifq.instr_valid) begin
                            push    = 1'b1;
                            pc_d    = npc;
                            state_d = S_ISSUE;
                        end
                    end
                    S_DISCARD: begin
                        if (ifq.instr_valid) begin
                            state_d = S_ISSUE;
                        end
                    end
                    default: state_d = S_ISSUE;
                endcase

                if (push) begin
                    tail_d = tail_q + PTR_W'(1);
                end
                if (pop) begin
                    head_d = head_q + PTR_W'(1);
                end
                case ({push, pop})
                    2'b10:   cnt_d = cnt_q + CNT_W'(1);
                    2'b01:   cnt_d = cnt_q - CNT_W'(1);
                    default: cnt_d = cnt_q;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin : ctrl_regs
        if (!rst) begin
            state_q <= S_ISSUE;
            pc_q    <= RESET_PC;
            head_q  <= '0;
            tail_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            cnt_q   <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin : queue_storage
        if (!rst) begin
            q_mem_q <= '{default: '0};
        end else if (push) begin
            q_mem_q[tail_q] <= new_entry;
        end
    end

    // 2-bit saturating counter update; fetch lookups read the pre-update value.
    always_comb begin : bht_next
        upd_idx  = BHT_IDX_W'(ifq.bht_upd_pc >> 2);
        upd_ctr  = bht_q[upd_idx];
        upd_next = upd_ctr;
        if (ifq.bht_upd_taken) begin
            if (upd_ctr != 2'b11) begin
                upd_next = upd_ctr + 2'd1;
            end
        end else if (upd_ctr != 2'b00) begin
            upd_next = upd_ctr - 2'd1;
        end
    end

    always_ff @(posedge clk) begin : bht_regs
        if (!rst) begin
            bht_q <= '{default: 2'b01};
        end else if (rdy && ifq.bht_upd_valid) begin
            bht_q[upd_idx] <= upd_next;
        end
    end

    assign head_entry          = q_mem_q[head_q];
    assign ifq.fetch_valid     = fetch_valid_c;
    assign ifq.pc_to_fetch     = pc_q;
    assign ifq.out_valid       = (cnt_q != '0);
    assign ifq.instr_to_decode = head_entry.instr;
    assign ifq.pc_to_decode    = head_entry.pc;
    assign ifq.is_jump_instr   = head_entry.is_jump;
    assign ifq.jump_prediction = head_entry.pred;
endmodule

// File: tb/tb_ifetch_queue.sv
// Directed bench for ifetch_queue with a small fixed-latency ICache responder.
module tb_ifetch_queue;
    logic clk = 1'b0;
    logic rst;
    logic rdy;

    ifetch_queue_if ifq ();

    ifetch_queue #(
        .QUEUE_DEPTH_LOG(3),
        .BHT_IDX_W      (8),
        .RESET_PC       (32'h0)
    ) dut (
        .clk(clk),
        .rst(rst),
        .rdy(rdy),
        .ifq(ifq)
    );

    always #5 clk = ~clk;

    int          n_chk = 0;
    int          n_err = 0;
    bit          prog_sel = 1'b0;
    logic [31:0] req_log [$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] prog(input logic [31:0] a);
        if (prog_sel && a == 32'h10) return 32'h0100006F;
        if (prog_sel && a == 32'h40) return 32'h00000463;
        return 32'h00000013;
    endfunction

    // ICache: answers each accepted request two idle cycles later; stalls with rdy, cleared by reset.
    initial begin : icache
        logic        fv_s, rdy_s, rst_s;
        logic [31:0] pc_s, req_pc;
        int          lat;
        bit          pend;
        pend = 1'b0;
        lat = 0;
        req_pc = '0;
        forever begin
            @(negedge clk);
            fv_s  = ifq.fetch_valid;
            pc_s  = ifq.pc_to_fetch;
            rdy_s = rdy;
            rst_s = rst;
            @(posedge clk);
            #1;
            if (!rst_s) begin
                pend            = 1'b0;
                ifq.instr_valid = 1'b0;
            end else if (rdy_s) begin
                ifq.instr_valid = 1'b0;
                if (pend) begin
                    lat--;
                    if (lat == 0) begin
                        ifq.instr_valid   = 1'b1;
                        ifq.instr_fetched = prog(req_pc);
                        pend              = 1'b0;
                    end
                end
                if (fv_s) begin
                    pend   = 1'b1;
                    lat    = 2;
                    req_pc = pc_s;
                    req_log.push_back(pc_s);
                end
            end
        end
    end

    task automatic redirect(input logic [31:0] tgt);
        @(posedge clk); #1;
        ifq.jump_wrong = 1'b1;
        ifq.jump_pc    = tgt;
        @(posedge clk); #1;
        ifq.jump_wrong = 1'b0;
        req_log.delete();
    endtask

    task automatic bht_upd(input logic taken);
        @(posedge clk); #1;
        ifq.bht_upd_valid = 1'b1;
        ifq.bht_upd_pc    = 32'h40;
        ifq.bht_upd_taken = taken;
        @(posedge clk); #1;
        ifq.bht_upd_valid = 1'b0;
    endtask

    task automatic wait_log(input int n, input string tag);
        int i = 0;
        do begin
            @(negedge clk);
            i++;
        end while (req_log.size() < n && i < 200);
        check_eq({tag, "_reqs"}, 32'(req_log.size() >= n), 32'd1);
    endtask

    task automatic wait_ov(input string tag);
        int i = 0;
        do begin
            @(negedge clk);
            i++;
        end while (!ifq.out_valid && i < 200);
        check_eq({tag, "_ov"}, 32'(ifq.out_valid), 32'd1);
    endtask

    task automatic check_head(input string tag, input logic [31:0] pc, input logic [31:0] ins,
                              input logic isj, input logic pred);
        check_eq({tag, "_pc"},   ifq.pc_to_decode, pc);
        check_eq({tag, "_ins"},  ifq.instr_to_decode, ins);
        check_eq({tag, "_jmp"},  32'(ifq.is_jump_instr), 32'(isj));
        check_eq({tag, "_pred"}, 32'(ifq.jump_prediction), 32'(pred));
    endtask

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin : stim
        rst = 1'b0;
        rdy = 1'b1;
        ifq.jump_wrong    = 1'b0;
        ifq.jump_pc       = '0;
        ifq.bht_upd_valid = 1'b0;
        ifq.bht_upd_pc    = '0;
        ifq.bht_upd_taken = 1'b0;
        ifq.instr_valid   = 1'b0;
        ifq.instr_fetched = '0;
        ifq.stall_IF      = 1'b1;

        // Reset state
        repeat (3) @(negedge clk);
        check_eq("rst_fetch_valid", 32'(ifq.fetch_valid), 32'd0);
        check_eq("rst_out_valid",   32'(ifq.out_valid), 32'd0);
        check_head("rst_head", 32'h0, 32'h0, 1'b0, 1'b0);
        @(posedge clk); #1;
        rst = 1'b1;

        // Fill to depth 8 under stall, then drain one per cycle
        repeat (60) @(negedge clk);
        check_eq("fill_count", 32'(req_log.size()), 32'd8);
        check_eq("fill_pc0", req_log[0], 32'h0);
        check_eq("fill_pc1", req_log[1], 32'h4);
        check_eq("fill_pc7", req_log[7], 32'h1C);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check_eq($sformatf("full_no_fetch%0d", k), 32'(ifq.fetch_valid), 32'd0);
        end
        check_eq("full_ov", 32'(ifq.out_valid), 32'd1);
        check_head("full_head", 32'h0, 32'h13, 1'b0, 1'b0);
        @(posedge clk); #1;
        ifq.stall_IF = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            check_eq($sformatf("drain_ov%0d", k), 32'(ifq.out_valid), 32'd1);
            check_eq($sformatf("drain_pc%0d", k), ifq.pc_to_decode, 32'(4 * k));
        end
        wait_ov("refill");
        check_eq("refill_pc", ifq.pc_to_decode, 32'h20);

        // JAL at 0x10, offset +16
        prog_sel     = 1'b1;
        ifq.stall_IF = 1'b1;
        redirect(32'h10);
        wait_ov("jal");
        check_head("jal_head", 32'h10, 32'h0100006F, 1'b1, 1'b1);
        wait_log(2, "jal");
        check_eq("jal_req0", req_log[0], 32'h10);
        check_eq("jal_next", req_log[1], 32'h20);

        // Branch at 0x40, offset +8: weak not-taken after reset
        redirect(32'h40);
        wait_ov("br_init");
        check_head("br_init_head", 32'h40, 32'h00000463, 1'b1, 1'b0);
        wait_log(2, "br_init");
        check_eq("br_init_next", req_log[1], 32'h44);

        // Two taken updates: 01 -> 11
        bht_upd(1'b1);
        bht_upd(1'b1);
        redirect(32'h40);
        wait_ov("br_tk");
        check_head("br_tk_head", 32'h40, 32'h00000463, 1'b1, 1'b1);
        wait_log(2, "br_tk");
        check_eq("br_tk_next", req_log[1], 32'h48);

        // Four not-taken: 11 -> 00 (saturates)
        repeat (4) bht_upd(1'b0);
        redirect(32'h40);
        wait_ov("br_nt");
        check_eq("br_nt_pred", 32'(ifq.jump_prediction), 32'd0);
        wait_log(2, "br_nt");
        check_eq("br_nt_next", req_log[1], 32'h44);

        // One taken from saturated zero gives 01: still not-taken
        bht_upd(1'b1);
        redirect(32'h40);
        wait_ov("br_sat");
        check_eq("br_sat_pred", 32'(ifq.jump_prediction), 32'd0);
        wait_log(2, "br_sat");
        check_eq("br_sat_next", req_log[1], 32'h44);

        // Redirect while waiting with 3 entries queued
        prog_sel = 1'b0;
        redirect(32'h200);
        wait_log(4, "flush_setup");
        check_eq("flush_req3", req_log[3], 32'h20C);
        check_eq("flush_pre_ov", 32'(ifq.out_valid), 32'd1);
        check_eq("flush_pre_head", ifq.pc_to_decode, 32'h200);
        redirect(32'h100);
        @(negedge clk);
        check_eq("flush_ov", 32'(ifq.out_valid), 32'd0);
        wait_log(1, "flush");
        check_eq("flush_next", req_log[0], 32'h100);
        wait_ov("flush");
        check_eq("flush_head", ifq.pc_to_decode, 32'h100);

        // rdy low for 5 cycles while waiting
        redirect(32'h300);
        wait_log(2, "hold_setup");
        check_eq("hold_req1", req_log[1], 32'h304);
        @(posedge clk); #1;
        rdy          = 1'b0;
        ifq.stall_IF = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check_eq($sformatf("hold_fv%0d", k),   32'(ifq.fetch_valid), 32'd0);
            check_eq($sformatf("hold_pcf%0d", k),  ifq.pc_to_fetch, 32'h304);
            check_eq($sformatf("hold_ov%0d", k),   32'(ifq.out_valid), 32'd1);
            check_eq($sformatf("hold_head%0d", k), ifq.pc_to_decode, 32'h300);
        end
        @(posedge clk); #1;
        rdy = 1'b1;
        @(negedge clk);
        check_eq("resume_head0", ifq.pc_to_decode, 32'h300);
        wait_ov("resume");
        check_eq("resume_head1", ifq.pc_to_decode, 32'h304);
        wait_log(3, "resume");
        check_eq("resume_next", req_log[2], 32'h308);

        // Reset while a request is outstanding
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        check_eq("rst2_fv", 32'(ifq.fetch_valid), 32'd0);
        check_eq("rst2_ov", 32'(ifq.out_valid), 32'd0);
        check_eq("rst2_pcd", ifq.pc_to_decode, 32'h0);
        @(posedge clk); #1;
        rst = 1'b1;
        req_log.delete();
        wait_log(1, "rst2");
        check_eq("rst2_first_pc", req_log[0], 32'h0);
        wait_ov("rst2");
        check_eq("rst2_head", ifq.pc_to_decode, 32'h0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
